// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the PC, issues one imem read at a time and
// hands the fetched word plus pre-sliced decode fields to decode.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        valid_next;
  logic        load;
  logic [31:0] load_inst;
  logic        load_fault;
  logic        misaligned;

  assign misaligned     = (pc[1:0] != 2'b00);
  assign imem_req_valid = (state == S_REQ) && !misaligned;
  assign imem_req_addr  = pc;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[30];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_next;
  end

  // Redirect is tested first in every state so it overrides all other moves.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = inst_valid;
    load       = 1'b0;
    load_inst  = imem_resp_data;
    load_fault = imem_resp_err;
    case (state)
      S_BOOT: begin
        state_next = S_REQ;
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          valid_next = 1'b0;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          valid_next = 1'b0;
          state_next = (imem_req_valid && imem_req_ready) ? S_DROP : S_REQ;
        end else if (misaligned) begin
          load       = 1'b1;
          load_inst  = NOP_INST;
          load_fault = 1'b1;
          valid_next = 1'b1;
          state_next = S_HOLD;
        end else if (imem_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          valid_next = 1'b0;
          state_next = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          load       = 1'b1;
          valid_next = 1'b1;
          pc_next    = pc + 32'd4;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          valid_next = 1'b0;
          state_next = S_REQ;
        end else if (inst_ready) begin
          valid_next = 1'b0;
          state_next = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          valid_next = 1'b0;
        end
        if (imem_resp_valid) state_next = S_REQ;
      end
      default: state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      pc         <= pc_next;
      inst_valid <= valid_next;
      if (load) begin
        inst       <= load_inst;
        inst_pc    <= pc;
        inst_fault <= load_fault;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus a randomized run, with a
// behavioural memory and an instruction-stream reference model.
module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7;

  ifu_fetch #(
    .RESET_PC(32'h8000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_hs     = 0;
  logic        rand_mode = 1'b0;
  logic        err_en    = 1'b0;
  int unsigned mem_lat   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0093;
    if (a == 32'h8000_0004) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h2545_F491;
    return (a == 32'h8000_0008) || (err_en && (h[31:29] == 3'd0));
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory: one response per accepted request, 1 + lat cycles later.
  logic        pend, acc, fire, rstlow;
  logic [31:0] pend_addr, acc_addr;
  int unsigned lat;
  initial begin
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;
    pend = 1'b0;
    lat  = 0;
    forever begin
      @(negedge clk);
      rstlow   = !rst_n;
      acc      = (imem_req_valid === 1'b1) && imem_req_ready;
      fire     = imem_resp_valid;
      acc_addr = imem_req_addr;
      @(posedge clk);
      #1;
      if (rstlow) begin
        pend = 1'b0;
        imem_resp_valid = 1'b0;
      end else begin
        if (fire) begin
          imem_resp_valid = 1'b0;
          pend = 1'b0;
        end
        if (acc) begin
          check_eq("one_outstanding", {31'd0, pend}, 32'd0);
          pend = 1'b1;
          pend_addr = acc_addr;
          lat = rand_mode ? $urandom_range(0, 3) : mem_lat;
        end
        if (pend && !imem_resp_valid) begin
          if (lat == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend_addr);
            imem_resp_err   = mem_err(pend_addr);
          end else begin
            lat--;
          end
        end
      end
      imem_req_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Reference model: the next instruction decode should see is the one at
  // exp_pc; a handshake advances it, a redirect replaces it.
  logic [31:0] exp_pc = 32'h8000_0000;
  logic [31:0] exp_word;
  logic        exp_fault;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_pc = 32'h8000_0000;
      end else begin
        if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_pc);
        if (inst_valid && inst_ready) begin
          if (exp_pc[1:0] != 2'b00) begin
            exp_word  = 32'h0000_0013;
            exp_fault = 1'b1;
          end else begin
            exp_word  = mem_word(exp_pc);
            exp_fault = mem_err(exp_pc);
          end
          check_eq("sb_inst_pc", inst_pc, exp_pc);
          check_eq("sb_inst", inst, exp_word);
          check_eq("sb_fault", {31'd0, inst_fault}, {31'd0, exp_fault});
          check_eq("sb_fields", {20'd0, funct7, funct3, opcode},
                   {20'd0, exp_word[30], exp_word[14:12], exp_word[6:0]});
          n_hs++;
          if (exp_pc[1:0] == 2'b00) exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) exp_pc = redirect_pc;
      end
    end
  end

  task automatic wait_inst();
    for (int i = 0; i < 40 && !inst_valid; i++) cycle();
    check_eq("wait_inst_timeout", {31'd0, inst_valid}, 32'd1);
  endtask

  task automatic wait_accept();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req_valid && imem_req_ready;
    end
    check_eq("wait_accept_timeout", {31'd0, seen}, 32'd1);
    cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check_eq({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    check_eq({tag, "_inst"}, inst, 32'd0);
    check_eq({tag, "_inst_pc"}, inst_pc, 32'd0);
    check_eq({tag, "_fault"}, {31'd0, inst_fault}, 32'd0);
  endtask

  initial begin
    int unsigned hs_start;
    logic [31:0] held_pc, held_inst;
    rst_n = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    cycle();
    cycle();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cycle();
    check_eq("boot_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check_eq("boot_req_addr", imem_req_addr, 32'h8000_0000);

    // Zero-wait fetch of the first two words.
    inst_ready = 1'b1;
    wait_inst();
    check_eq("first_pc", inst_pc, 32'h8000_0000);
    check_eq("first_inst", inst, 32'h0000_0093);
    check_eq("first_opcode", {25'd0, opcode}, 32'h13);
    check_eq("first_funct3", {29'd0, funct3}, 32'd0);
    cycle();
    check_eq("second_req_addr", imem_req_addr, 32'h8000_0004);
    inst_ready = 1'b0;
    wait_inst();
    check_eq("second_pc", inst_pc, 32'h8000_0004);
    check_eq("second_inst", inst, 32'h0010_0113);

    // Decode back-pressure holds everything stable.
    held_pc = inst_pc;
    held_inst = inst;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("bp_valid", {31'd0, inst_valid}, 32'd1);
      check_eq("bp_no_req", {31'd0, imem_req_valid}, 32'd0);
      check_eq("bp_pc", inst_pc, held_pc);
      check_eq("bp_inst", inst, held_inst);
    end
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    check_eq("bp_release_req", {31'd0, imem_req_valid}, 32'd1);
    check_eq("bp_release_addr", imem_req_addr, 32'h8000_0008);

    // Access fault at 0x80000008, clean fetch after it.
    wait_inst();
    check_eq("err_pc", inst_pc, 32'h8000_0008);
    check_eq("err_fault", {31'd0, inst_fault}, 32'd1);
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    wait_inst();
    check_eq("after_err_pc", inst_pc, 32'h8000_000C);
    check_eq("after_err_fault", {31'd0, inst_fault}, 32'd0);
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;

    // Redirect while waiting on a slow response.
    mem_lat = 3;
    wait_accept();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !imem_req_valid; i++) begin
      check_eq("squash_no_valid", {31'd0, inst_valid}, 32'd0);
      cycle();
    end
    check_eq("redirect_req_addr", imem_req_addr, 32'h8000_0100);
    wait_inst();
    check_eq("redirect_pc", inst_pc, 32'h8000_0100);

    // Misaligned redirect produces a faulting NOP with no request.
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    cycle();
    redirect_valid = 1'b0;
    check_eq("misalign_no_req", {31'd0, imem_req_valid}, 32'd0);
    wait_inst();
    check_eq("misalign_inst", inst, 32'h0000_0013);
    check_eq("misalign_fault", {31'd0, inst_fault}, 32'd1);
    check_eq("misalign_pc", inst_pc, 32'h8000_0102);

    // Redirect coinciding with a completed handshake.
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0010;
    cycle();
    redirect_valid = 1'b0;
    check_eq("hold_redirect_addr", imem_req_addr, 32'h8000_0010);
    inst_ready = 1'b0;

    // Reset in the middle of a fetch.
    wait_accept();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check_reset_outputs("midreset");
    cycle();
    check_eq("midreset_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check_eq("midreset_req_addr", imem_req_addr, 32'h8000_0000);

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    cycle();
    err_en = 1'b1;
    rand_mode = 1'b1;
    rst_n = 1'b1;
    hs_start = n_hs;
    for (int i = 0; i < 4000; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = 32'h8000_0000 + ($urandom_range(0, 63) << 2);
      if ($urandom_range(0, 7) == 0) redirect_pc = redirect_pc + $urandom_range(1, 3);
      cycle();
    end
    redirect_valid = 1'b0;
    check_eq("random_progress", {31'd0, (n_hs - hs_start) > 100}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
